pulse_spacer: RTL and testbench
===============================

// Module: pulse_spacer
// PURPOSE
//   Fast-domain stage upstream of the toggle-based pulse synchronizer.
//   Collects single-cycle event strobes, which may be back-to-back, into a backlog counter.
//   Re-emits them as single-cycle pulses spaced at least MIN_GAP clocks apart.
//   The spacing lets every pulse survive the toggle crossing into the slow domain.
//   Overflow of the backlog is flagged, never silently wrapped.
// PARAMETERS
//   MIN_GAP  8  clk cycles from one pulse_out assertion to the next; legal range >= 1
//   CNT_W    4  backlog counter width; capacity PMAX = 2**CNT_W - 1 events
// PORTS
//   clk        in   1      fast-domain clock, same clock as the synchronizer's source side
//   rst_n      in   1      asynchronous active-low reset
//   evt_in     in   1      event strobe; each high cycle counts as one event
//   clr_ovf    in   1      clears the sticky ovf flag
//   pulse_out  out  1      registered single-cycle pulse; feeds the synchronizer data_in
//   pending    out  CNT_W  events accepted but not yet emitted
//   busy       out  1      high when pending != 0 or the FSM is in GAP
//   ovf        out  1      sticky flag; an event was dropped because the backlog was full
// BEHAVIOUR
//   Reset (async, rst_n low)
//     - pulse_out, pending, ovf, busy = 0; gap_cnt = 0; FSM = IDLE.
//     - Takes effect immediately, including mid-backlog. All queued events are discarded.
//   FSM and gap counter
//     - gap_cnt width = clog2(MIN_GAP + 1).
//     - FSM state IDLE <=> gap_cnt == 0; state GAP <=> gap_cnt != 0.
//     - fire = (gap_cnt == 0) && (pending != 0), evaluated from register values before the edge.
//   Per rising edge
//     - pulse_out <= fire.
//     - gap_cnt   <= fire ? MIN_GAP-1 : (gap_cnt != 0 ? gap_cnt-1 : 0).
//     - FSM transitions: IDLE -> GAP on fire when MIN_GAP > 1; GAP -> IDLE when gap_cnt reaches 0.
//     - Spacing: consecutive pulse_out assertions are exactly MIN_GAP cycles apart while backlog exists.
//     - MIN_GAP = 1: GAP is never entered and pulses may be back-to-back.
//   Backlog arithmetic
//     - inc = evt_in && !(pending == PMAX && !fire).
//     - pending <= pending + inc - fire.
//     - Simultaneous inc and fire leaves pending unchanged.
//     - evt_in with pending == PMAX and fire = 1 is accepted; pending stays PMAX and ovf is not set.
//     - evt_in with pending == PMAX and fire = 0 is dropped; pending stays PMAX.
//     - pending never wraps.
//   Overflow flag
//     - ovf <= drop ? 1 : (clr_ovf ? 0 : ovf).
//     - Set wins over clear in the same cycle.
//   Latency and busy
//     - Idle block, empty backlog: evt_in sampled at edge N -> pending = 1 after N -> pulse_out high for the cycle after edge N+1.
//     - busy is combinational from registers: (pending != 0) || (gap_cnt != 0).
//   Mode of operation
//     - No handshake: events are fire-and-forget.
//     - Producers that must be lossless must keep the event rate below 1/MIN_GAP on average and bursts below PMAX.
// TESTING  (MIN_GAP = 4, CNT_W = 3, PMAX = 7 unless noted)
//   1 Single event
//     - One-cycle evt_in at idle -> one pulse_out cycle 2 edges after sampling.
//     - pending 1 -> 0; busy low 4 cycles after the pulse edge.
//   2 Five-cycle burst
//     - evt_in high edges 1-5 -> pulses after edges 2, 6, 10, 14, 18.
//     - pending peaks at 4; no ovf.
//   3 Twelve-cycle burst (saturation)
//     - evt_in high edges 1-12 -> pending reaches 7 at edge 9; edge 10 fire+inc keeps 7.
//     - Drops at edges 11 and 12; ovf = 1; exactly 10 pulses total, all 4 apart.
//   4 Overflow flag
//     - clr_ovf one cycle with no drop -> ovf = 0.
//     - clr_ovf asserted in the same cycle as a drop -> ovf remains 1.
//   5 Reset mid-backlog
//     - rst_n low with pending = 3 in GAP -> all outputs 0 immediately.
//     - After release with evt_in = 0 -> no pulse_out for 20 cycles.
//   6 MIN_GAP = 1 build
//     - evt_in high edges 1-3 -> pulse_out high after edges 2, 3, 4 (3 back-to-back cycles).
//     - pending ends at 0.

Source files
------------

// File: rtl/pulse_spacer.sv
// ----------------------------------------------------------------------------
// pulse_spacer
//   Fast-domain stage that sits in front of a toggle-based pulse synchronizer.
//   Single-cycle event strobes arrive on evt_in, possibly back-to-back. Each
//   one is added to a backlog counter. The block then re-emits the events as
//   single-cycle pulses spaced MIN_GAP clocks apart, so that every pulse
//   survives the toggle crossing into the slow domain. An event that arrives
//   while the backlog is full is dropped, and the drop is recorded in a sticky
//   flag.
//
// Parameters
//   MIN_GAP   clocks from one pulse_out assertion to the next (>= 1)
//   CNT_W     backlog counter width; capacity is 2**CNT_W - 1 events
//
// Ports
//   clk        in   1      fast-domain clock
//   rst_n      in   1      asynchronous active-low reset
//   evt_in     in   1      event strobe; each high cycle is one event
//   clr_ovf    in   1      clears the sticky ovf flag
//   pulse_out  out  1      registered single-cycle pulse to the synchronizer
//   pending    out  CNT_W  events accepted but not yet emitted
//   busy       out  1      backlog non-empty or gap timer running
//   ovf        out  1      sticky: an event was dropped on a full backlog
// ----------------------------------------------------------------------------
module pulse_spacer #(
    parameter int MIN_GAP = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
);

    localparam int               GW         = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0]    GAP_RELOAD = GW'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] PMAX       = '1;

    typedef enum logic {
        IDLE = 1'b0,   // gap timer expired; a pulse may be issued
        GAP  = 1'b1    // gap timer running; pulses are held back
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    gap_cnt_q;
    logic [CNT_W-1:0] pending_q;
    logic             pulse_q;
    logic             ovf_q;

    logic fire;
    logic drop;
    logic inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is assigned with <= so every register samples the
    // pre-edge values of its neighbours; a blocking = here would let one
    // register see another's already-updated value and break the arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    //   IDLE -> GAP on a pulse, unless the gap is a single cycle (then the
    //   block can fire again on the very next edge and never waits).
    //   GAP -> IDLE on the edge where the gap timer reaches zero.
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so every path assigns it;
    // a missing assignment in combinational logic would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fire && (MIN_GAP > 1)) state_d = GAP;
            GAP:  if (gap_cnt_q == GW'(1))   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode (all from registered values)
    //   A drop happens only when the backlog is full and nothing leaves
    //   this cycle; if a pulse fires, the slot it frees takes the new event.
    // ------------------------------------------------------------------
    always_comb begin
        fire = (state_q == IDLE) && (pending_q != '0);
        drop = evt_in && (pending_q == PMAX) && !fire;
        inc  = evt_in && !drop;
        busy = (pending_q != '0) || (gap_cnt_q != '0);
    end

    // ------------------------------------------------------------------
    // Datapath: pulse register, gap timer, backlog counter, sticky flag
    // ------------------------------------------------------------------
    // NOTE: every register here is a plain flop, so all of them take the
    // asynchronous reset; a mid-backlog reset discards queued events at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q   <= 1'b0;
            gap_cnt_q <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pulse_q <= fire;

            if (fire) begin
                gap_cnt_q <= GAP_RELOAD;
            end else if (gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GW'(1);
            end

            // inc and fire together leave the count unchanged
            if (inc && !fire) begin
                pending_q <= pending_q + CNT_W'(1);
            end else if (fire && !inc) begin
                pending_q <= pending_q - CNT_W'(1);
            end

            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_spacer.sv
// ----------------------------------------------------------------------------
// tb_pulse_spacer
//   Two instances: u_dut (MIN_GAP = 4, CNT_W = 3) and u_dut1 (MIN_GAP = 1,
//   CNT_W = 3). Stimulus pushes the absolute edge number after which each
//   pulse is expected into a per-instance queue; independent monitors pop
//   and compare whenever pulse_out is seen high. Register state (pending,
//   busy, ovf) is checked directly by the stimulus thread at fixed points.
// ----------------------------------------------------------------------------
module tb_pulse_spacer;

    logic       clk;
    logic       rst_n;
    logic       evt_in;
    logic       evt_in1;
    logic       clr_ovf;
    logic       pulse_out,  busy,  ovf;
    logic       pulse_out1, busy1, ovf1;
    logic [2:0] pending, pending1;

    int total = 0;
    int bad   = 0;
    int edge_cnt  = 0;
    int pulse_cnt = 0;
    int exp_q0[$];
    int exp_q1[$];

    pulse_spacer #(.MIN_GAP(4), .CNT_W(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_in    (evt_in),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out),
        .pending   (pending),
        .busy      (busy),
        .ovf       (ovf)
    );

    pulse_spacer #(.MIN_GAP(1), .CNT_W(3)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_in    (evt_in1),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out1),
        .pending   (pending1),
        .busy      (busy1),
        .ovf       (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && pulse_out) begin
            pulse_cnt++;
            if (exp_q0.size() == 0) check("dut_unexpected_pulse", int'(pulse_out), 0);
            else                    check("dut_pulse_edge", edge_cnt, exp_q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && pulse_out1) begin
            if (exp_q1.size() == 0) check("dut1_unexpected_pulse", int'(pulse_out1), 0);
            else                    check("dut1_pulse_edge", edge_cnt, exp_q1.pop_front());
        end
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base;
    int peak;
    int pc0;

    initial begin
        rst_n   = 1'b0;
        evt_in  = 1'b0;
        evt_in1 = 1'b0;
        clr_ovf = 1'b0;
        step(2);
        check("rst_pulse_out", int'(pulse_out), 0);
        check("rst_pending",   int'(pending),   0);
        check("rst_busy",      int'(busy),      0);
        check("rst_ovf",       int'(ovf),       0);
        rst_n = 1'b1;
        step(2);

        // ---- 1: single event -----------------------------------------
        base = edge_cnt;
        exp_q0.push_back(base + 2);
        evt_in = 1'b1;
        step(1);                                   // edge 1
        evt_in = 1'b0;
        check("t1_pending_e1", int'(pending),   1);
        check("t1_pulse_e1",   int'(pulse_out), 0);
        step(1);                                   // edge 2
        check("t1_pending_e2", int'(pending),   0);
        check("t1_pulse_e2",   int'(pulse_out), 1);
        step(1);                                   // edge 3
        check("t1_pulse_e3",   int'(pulse_out), 0);
        step(1);                                   // edge 4
        check("t1_busy_e4",    int'(busy),      1);
        step(1);                                   // edge 5
        check("t1_busy_e5",    int'(busy),      0);
        step(3);

        // ---- 2: five-cycle burst -------------------------------------
        base = edge_cnt;
        for (int k = 0; k < 5; k++) exp_q0.push_back(base + 2 + 4 * k);
        peak = 0;
        evt_in = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            if (int'(pending) > peak) peak = int'(pending);
        end
        evt_in = 1'b0;
        for (int e = 6; e <= 19; e++) begin
            step(1);
            if (int'(pending) > peak) peak = int'(pending);
        end
        check("t2_peak",    peak,           4);
        check("t2_ovf",     int'(ovf),      0);
        check("t2_pending", int'(pending),  0);
        step(4);

        // ---- 3: twelve-cycle burst, saturation -----------------------
        base = edge_cnt;
        pc0  = pulse_cnt;
        for (int k = 0; k < 10; k++) exp_q0.push_back(base + 2 + 4 * k);
        evt_in = 1'b1;
        step(9);                                   // edge 9
        check("t3_pending_e9",  int'(pending), 7);
        step(1);                                   // edge 10: fire + inc
        check("t3_pending_e10", int'(pending), 7);
        check("t3_ovf_e10",     int'(ovf),     0);
        step(1);                                   // edge 11: drop
        check("t3_pending_e11", int'(pending), 7);
        check("t3_ovf_e11",     int'(ovf),     1);
        step(1);                                   // edge 12: drop
        evt_in = 1'b0;
        step(33);                                  // edge 45
        check("t3_pending_end", int'(pending),   0);
        check("t3_ovf_end",     int'(ovf),       1);
        check("t3_pulse_count", pulse_cnt - pc0, 10);

        // ---- 4: overflow flag clear / set-wins ------------------------
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t4_clr_no_drop", int'(ovf), 0);
        step(3);
        base = edge_cnt;
        for (int k = 0; k < 10; k++) exp_q0.push_back(base + 2 + 4 * k);
        evt_in = 1'b1;
        step(10);                                  // edge 10
        check("t4_ovf_e10", int'(ovf), 0);
        clr_ovf = 1'b1;
        step(1);                                   // edge 11: drop + clear
        evt_in  = 1'b0;
        clr_ovf = 1'b0;
        check("t4_set_wins", int'(ovf), 1);
        step(30);                                  // edge 41
        check("t4_pending_end", int'(pending), 0);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("t4_ovf_cleared", int'(ovf), 0);
        step(3);

        // ---- 5: reset mid-backlog ------------------------------------
        base = edge_cnt;
        exp_q0.push_back(base + 2);
        evt_in = 1'b1;
        step(4);                                   // edge 4: pending 3, in GAP
        evt_in = 1'b0;
        check("t5_pending_pre", int'(pending), 3);
        check("t5_busy_pre",    int'(busy),    1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_pulse_out", int'(pulse_out), 0);
        check("t5_rst_pending",   int'(pending),   0);
        check("t5_rst_busy",      int'(busy),      0);
        check("t5_rst_ovf",       int'(ovf),       0);
        #1;
        rst_n = 1'b1;
        pc0 = pulse_cnt;
        step(20);
        check("t5_no_pulses",  pulse_cnt - pc0, 0);
        check("t5_pending_end", int'(pending),  0);

        // ---- 6: MIN_GAP = 1 instance ---------------------------------
        base = edge_cnt;
        for (int k = 2; k <= 4; k++) exp_q1.push_back(base + k);
        evt_in1 = 1'b1;
        step(3);                                   // edge 3
        evt_in1 = 1'b0;
        check("t6_pending_e3", int'(pending1), 1);
        step(1);                                   // edge 4
        check("t6_pending_e4", int'(pending1), 0);
        check("t6_pulse_e4",   int'(pulse_out1), 1);
        step(1);                                   // edge 5
        check("t6_pulse_e5",   int'(pulse_out1), 0);
        check("t6_busy_e5",    int'(busy1),      0);
        check("t6_ovf",        int'(ovf1),       0);
        step(2);

        check("q0_left", exp_q0.size(), 0);
        check("q1_left", exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: time limit reached");
        $fatal(1, "timeout");
    end

endmodule
